// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a one-word holding buffer in front of the shifter.
module uart_tx_cfg #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int LSB_FIRST    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              serial_out,
   output logic              busy,
   output logic              tx_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] shreg_q, shreg_d, buf_q, buf_d;
   logic              buf_full_q, buf_full_d, par_q, par_d, serial_out_q, serial_out_d;
   logic              bit_end, load, accept;

   always_comb begin
      bit_end    = cnt_q == CNT_LAST;
      tx_done    = state_q == STOP && bit_end && idx_q == STOP_LAST;
      load       = buf_full_q && (state_q == IDLE || tx_done);
      tx_ready   = !buf_full_q && !reset;
      busy       = state_q != IDLE || buf_full_q;
      accept     = tx_valid && tx_ready;
      buf_d      = accept ? tx_data : buf_q;
      buf_full_d = load ? 1'b0 : buf_full_q || accept;
      cnt_d      = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      state_d    = state_q;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      // a full buffer at the end of the last stop bit chains straight into the next start bit
      if (load) begin
         state_d = START;
         shreg_d = buf_q;
         par_d   = ^buf_q ^ (PARITY_MODE == 2);
         idx_d   = '0;
      end else if (bit_end) begin
         case (state_q)
            START:  state_d = DATA;
            DATA: begin
               idx_d   = idx_q == DATA_LAST ? '0 : idx_q + 1'b1;
               state_d = idx_q != DATA_LAST ? DATA : PARITY_MODE != 0 ? PARITY : STOP;
               shreg_d = LSB_FIRST != 0 ? shreg_q >> 1 : shreg_q << 1;
            end
            PARITY: state_d = STOP;
            STOP: begin
               idx_d   = idx_q == STOP_LAST ? '0 : idx_q + 1'b1;
               state_d = idx_q == STOP_LAST ? IDLE : STOP;
            end
            default: state_d = IDLE;
         endcase
      end
      serial_out_d = state_d == START  ? 1'b0 :
                     state_d == DATA   ? (LSB_FIRST != 0 ? shreg_d[0] : shreg_d[DATA_W-1]) :
                     state_d == PARITY ? par_d : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shreg_q      <= '0;
         buf_q        <= '0;
         buf_full_q   <= 1'b0;
         par_q        <= 1'b0;
         serial_out_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shreg_q      <= shreg_d;
         buf_q        <= buf_d;
         buf_full_q   <= buf_full_d;
         par_q        <= par_d;
         serial_out_q <= serial_out_d;
      end
   end

   assign serial_out = serial_out_q;
endmodule
